// File: rtl/axi4lite_debug_regs_pkg.sv
// Register indices, AXI response codes and the byte-strobe merge shared by the debug register block.
package axi4lite_debug_regs_pkg;

  localparam logic [2:0] REG_ID       = 3'd0;
  localparam logic [2:0] REG_SCRATCH  = 3'd1;
  localparam logic [2:0] REG_COUNTER  = 3'd2;
  localparam logic [2:0] REG_GPIO_OUT = 3'd3;
  localparam logic [2:0] REG_GPIO_IN  = 3'd4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [31:0] DEFAULT_ID_VALUE = 32'h5245_4753;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] cur,
                                              input logic [31:0] wd,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = cur;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = wd[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi4lite_debug_regs_sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; output lags input by 2 clk edges.
// No handshake: every bit is sampled every cycle.
module sync_2ff #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/axi4lite_debug_regs.sv
// AXI4-lite bring-up slave (ID/scratch/counter/GPIO); B one edge after AW+W are both held, R one edge after AR.
// One outstanding transaction per direction: AW/W/AR readiness drops while the matching response waits.
module axi4lite_debug_regs
  import axi4lite_debug_regs_pkg::*;
#(
  parameter int          C_S00_AXI_ADDR_WIDTH = 32,
  parameter int          C_S00_AXI_DATA_WIDTH = 32,
  parameter int          GPIO_WIDTH           = 8,
  parameter logic [31:0] ID_VALUE             = DEFAULT_ID_VALUE
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_areset,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                        s00_axi_awprot,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S00_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                        s00_axi_arprot,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready,
  output logic [GPIO_WIDTH-1:0]             gpio_out,
  input  logic [GPIO_WIDTH-1:0]             gpio_in
);

  logic            aw_held, w_held, commit, wr_err;
  logic [2:0]      aw_idx;
  logic [31:0]     w_data;
  logic [3:0]      w_strb;
  logic [31:0]     scratch, counter;
  logic [GPIO_WIDTH-1:0] gpio_in_sync;
  logic [31:0]     rd_val;
  logic            rd_err;
  logic            unused_ok;

  assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr, s00_axi_araddr};

  assign s00_axi_awready = !aw_held && !s00_axi_bvalid;
  assign s00_axi_wready  = !w_held && !s00_axi_bvalid;
  assign s00_axi_arready = !s00_axi_rvalid;
  assign commit          = aw_held && w_held;
  assign wr_err          = aw_idx > REG_GPIO_IN;

  sync_2ff #(.WIDTH(GPIO_WIDTH)) u_gpio_sync (
    .clk (s00_axi_aclk),
    .rst (s00_axi_areset),
    .d   (gpio_in),
    .q   (gpio_in_sync)
  );

  // AW and W latch independently; the commit edge retires both and raises B.
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      aw_held        <= 1'b0;
      aw_idx         <= '0;
      w_held         <= 1'b0;
      w_data         <= '0;
      w_strb         <= '0;
      s00_axi_bvalid <= 1'b0;
      s00_axi_bresp  <= RESP_OKAY;
    end else begin
      if (s00_axi_awvalid && s00_axi_awready) begin
        aw_held <= 1'b1;
        aw_idx  <= s00_axi_awaddr[4:2];
      end
      if (s00_axi_wvalid && s00_axi_wready) begin
        w_held <= 1'b1;
        w_data <= s00_axi_wdata;
        w_strb <= s00_axi_wstrb;
      end
      if (commit) begin
        aw_held        <= 1'b0;
        w_held         <= 1'b0;
        s00_axi_bvalid <= 1'b1;
        s00_axi_bresp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end else if (s00_axi_bvalid && s00_axi_bready) begin
        s00_axi_bvalid <= 1'b0;
      end
    end
  end

  // A counter write replaces that cycle's increment.
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      scratch  <= '0;
      counter  <= '0;
      gpio_out <= '0;
    end else begin
      counter <= counter + 32'd1;
      if (commit) begin
        case (aw_idx)
          REG_SCRATCH:  scratch  <= apply_wstrb(scratch, w_data, w_strb);
          REG_COUNTER:  counter  <= apply_wstrb(counter, w_data, w_strb);
          REG_GPIO_OUT: gpio_out <= GPIO_WIDTH'(apply_wstrb(32'(gpio_out), w_data, w_strb));
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rd_val = 32'hFFFF_FFFF;
    rd_err = 1'b1;
    case (s00_axi_araddr[4:2])
      REG_ID:       begin rd_val = ID_VALUE;          rd_err = 1'b0; end
      REG_SCRATCH:  begin rd_val = scratch;           rd_err = 1'b0; end
      REG_COUNTER:  begin rd_val = counter;           rd_err = 1'b0; end
      REG_GPIO_OUT: begin rd_val = 32'(gpio_out);     rd_err = 1'b0; end
      REG_GPIO_IN:  begin rd_val = 32'(gpio_in_sync); rd_err = 1'b0; end
      default: ;
    endcase
  end

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      s00_axi_rvalid <= 1'b0;
      s00_axi_rdata  <= '0;
      s00_axi_rresp  <= RESP_OKAY;
    end else if (s00_axi_arvalid && s00_axi_arready) begin
      s00_axi_rvalid <= 1'b1;
      s00_axi_rdata  <= rd_val;
      s00_axi_rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
    end else if (s00_axi_rvalid && s00_axi_rready) begin
      s00_axi_rvalid <= 1'b0;
    end
  end

endmodule
